// File: rtl/reward_unit_pkg.sv
// reward_unit_pkg
// Shared definitions for the reward unit: data word width, packet-type
// encoding, the broadcast destination ID, the FSM state encoding and a
// helper that decides whether a received packet earns a reward response.
// Optional feature macro used by this slice: REWARD_HOP_PENALTY_EN
// (see reward_unit_qcalc.sv).
package reward_unit_pkg;

   localparam int WORD_WIDTH = 16;

   typedef enum logic [2:0] {
      PKT_HB         = 3'd0,
      PKT_CH_ADV     = 3'd1,
      PKT_CH_JOIN    = 3'd2,
      PKT_DATA       = 3'd3,
      PKT_ACK        = 3'd4,
      PKT_SOS        = 3'd5,
      PKT_CH_TIMEOUT = 3'd6,
      PKT_RESERVED   = 3'd7
   } packetTypeT;

   localparam logic [WORD_WIDTH-1:0] BROADCAST_ID = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_CALC = 2'd2,
      ST_DONE = 2'd3
   } rewardStateT;

   // Heartbeats always get a reward reply; data only when addressed to us.
   function automatic logic isAccepted(input logic [2:0] pktType, input logic iAmDestination);
      return (pktType == PKT_HB) || ((pktType == PKT_DATA) && iAmDestination);
   endfunction

endpackage

// File: rtl/reward_unit_if.sv
// reward_unit_if
// Bundles everything the reward unit exchanges with its neighbours:
//   - start pulse and received packet fields (from the packet filter)
//   - own node info and cluster/routing state (from node-info registers)
//   - neighbor-table read port (index out, entry fields back same cycle)
//   - response packet fields and completion strobe (to the packet builder)
// Modports: master = surrounding system, slave = reward_unit.
interface reward_unit_if;
   import reward_unit_pkg::*;

   logic                  en;
   logic [2:0]            fPacketType;
   logic [WORD_WIDTH-1:0] myEnergy, myNodeID, hopsFromSink, myQValue;
   logic                  iHaveData, iAmDestination, role, low_E;
   logic [WORD_WIDTH-1:0] fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH;
   logic [WORD_WIDTH-1:0] chosenCH, hopsFromCH, chosenHop;
   logic [4:0]            neighborCount;
   logic [WORD_WIDTH-1:0] mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops;

   logic [WORD_WIDTH-1:0] rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH;
   logic [2:0]            rPacketType;
   logic [5:0]            nTableIndex_reward;
   logic                  reward_done;

   modport master (
      output en, fPacketType, myEnergy, myNodeID, hopsFromSink, myQValue,
             iHaveData, iAmDestination, role, low_E,
             fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH,
             chosenCH, hopsFromCH, chosenHop, neighborCount,
             mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops,
      input  rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH,
             rHopsFromCH, rPacketType, nTableIndex_reward, reward_done
   );

   modport slave (
      input  en, fPacketType, myEnergy, myNodeID, hopsFromSink, myQValue,
             iHaveData, iAmDestination, role, low_E,
             fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH,
             chosenCH, hopsFromCH, chosenHop, neighborCount,
             mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops,
      output rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH,
             rHopsFromCH, rPacketType, nTableIndex_reward, reward_done
   );
endinterface

// File: rtl/reward_unit_qcalc.sv
// reward_qcalc
// Combinational Q-value reward: halves own energy, optionally subtracts a
// hop penalty (REWARD_HOP_PENALTY_EN: (hopsFromSink<<8), floored at 0),
// adds half the best neighbor Q-value with saturation at 16'hFFFF, and
// forces zero when own energy is low.
// Ports: myEnergy, hopsFromSink, maxQ, lowEnergy in; qValue out.
module reward_qcalc
   import reward_unit_pkg::*;
(
   input  logic [WORD_WIDTH-1:0] myEnergy,
   input  logic [WORD_WIDTH-1:0] hopsFromSink,
   input  logic [WORD_WIDTH-1:0] maxQ,
   input  logic                  lowEnergy,
   output logic [WORD_WIDTH-1:0] qValue
);
   logic [WORD_WIDTH-1:0] halfEnergy;
   logic [WORD_WIDTH-1:0] baseReward;
   logic [WORD_WIDTH:0]   rawSum;

   assign halfEnergy = myEnergy >> 1;

`ifdef REWARD_HOP_PENALTY_EN
   // Penalty kept 24 bits wide so large hop counts cannot wrap into a
   // small value; whenever it is below halfEnergy it fits in 16 bits.
   logic [WORD_WIDTH+7:0] hopPenalty;
   assign hopPenalty = {hopsFromSink, 8'h00};
   assign baseReward = ({8'h00, halfEnergy} > hopPenalty)
                       ? (halfEnergy - hopPenalty[WORD_WIDTH-1:0]) : '0;
`else
   logic unusedHops;
   assign unusedHops = ^hopsFromSink;
   assign baseReward = halfEnergy;
`endif

   assign rawSum = {1'b0, baseReward} + {2'b00, maxQ[WORD_WIDTH-1:1]};

   always_comb begin
      qValue = rawSum[WORD_WIDTH-1:0];
      if (lowEnergy) begin
         qValue = '0;
      end else if (rawSum[WORD_WIDTH]) begin
         qValue = '1;
      end
   end
endmodule

// File: rtl/reward_unit.sv
// reward_unit
// On an accepted packet (HB always, DATA when addressed to this node) scans
// the neighbor table for the best Q-value among live (nonzero-energy)
// entries, computes this node's reward and registers a complete response
// packet. Rejected packets only produce the completion strobe.
// Ports: clk, nrst (asynchronous, active-high), bus (reward_unit_if.slave).
// Optional feature: REWARD_HOP_PENALTY_EN (hop penalty inside reward_qcalc).
module reward_unit
   import reward_unit_pkg::*;
(
   input  logic         clk,
   input  logic         nrst,
   reward_unit_if.slave bus
);
   rewardStateT           stateReg;
   logic [5:0]            idxReg;
   logic [4:0]            countReg;
   logic [WORD_WIDTH-1:0] maxQReg;
   logic [WORD_WIDTH-1:0] srcIdReg;
   logic                  isDataReg;
   logic                  doneReg;
   logic [WORD_WIDTH-1:0] rSourceIdReg, rEnergyReg, rQValueReg, rSourceHopsReg;
   logic [WORD_WIDTH-1:0] rDestIdReg, rChosenChReg, rHopsFromChReg;
   logic [2:0]            rTypeReg;
   logic [WORD_WIDTH-1:0] qValue;
   logic [5:0]            lastIdx;
   logic                  unusedInputs;

   reward_qcalc uQcalc (
      .myEnergy     (bus.myEnergy),
      .hopsFromSink (bus.hopsFromSink),
      .maxQ         (maxQReg),
      .lowEnergy    (bus.low_E),
      .qValue       (qValue)
   );

   // Only entered with countReg > 0, so this never underflows in SCAN.
   assign lastIdx = {1'b0, countReg} - 6'd1;

   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         stateReg       <= ST_IDLE;
         idxReg         <= '0;
         countReg       <= '0;
         maxQReg        <= '0;
         srcIdReg       <= '0;
         isDataReg      <= 1'b0;
         doneReg        <= 1'b0;
         rSourceIdReg   <= '0;
         rEnergyReg     <= '0;
         rQValueReg     <= '0;
         rSourceHopsReg <= '0;
         rDestIdReg     <= '0;
         rChosenChReg   <= '0;
         rHopsFromChReg <= '0;
         rTypeReg       <= '0;
      end else begin
         doneReg <= 1'b0;
         case (stateReg)
            ST_IDLE: begin
               if (bus.en) begin
                  if (isAccepted(bus.fPacketType, bus.iAmDestination)) begin
                     srcIdReg  <= bus.fSourceID;
                     isDataReg <= (bus.fPacketType == PKT_DATA);
                     maxQReg   <= (bus.fPacketType == PKT_DATA) ? bus.fQValue : '0;
                     idxReg    <= '0;
                     countReg  <= bus.neighborCount;
                     stateReg  <= (bus.neighborCount != 5'd0) ? ST_SCAN : ST_CALC;
                  end else begin
                     doneReg  <= 1'b1;
                     stateReg <= ST_DONE;
                  end
               end
            end
            ST_SCAN: begin
               // Dead neighbors (zero energy) are not eligible next hops.
               if ((bus.mNodeEnergy != '0) && (bus.mNodeQValue > maxQReg)) begin
                  maxQReg <= bus.mNodeQValue;
               end
               if (idxReg == lastIdx) begin
                  idxReg   <= '0;
                  stateReg <= ST_CALC;
               end else begin
                  idxReg <= idxReg + 6'd1;
               end
            end
            ST_CALC: begin
               rSourceIdReg   <= bus.myNodeID;
               rEnergyReg     <= bus.myEnergy;
               rQValueReg     <= qValue;
               rSourceHopsReg <= bus.hopsFromSink;
               rChosenChReg   <= bus.chosenCH;
               rHopsFromChReg <= bus.role ? '0 : bus.hopsFromCH;
               rTypeReg       <= isDataReg ? PKT_ACK : PKT_HB;
               rDestIdReg     <= isDataReg ? srcIdReg : BROADCAST_ID;
               doneReg        <= 1'b1;
               stateReg       <= ST_DONE;
            end
            ST_DONE: begin
               stateReg <= ST_IDLE;
            end
            default: begin
               stateReg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rSourceID          = rSourceIdReg;
   assign bus.rEnergyLeft        = rEnergyReg;
   assign bus.rQValue            = rQValueReg;
   assign bus.rSourceHops        = rSourceHopsReg;
   assign bus.rDestinationID     = rDestIdReg;
   assign bus.rChosenCH          = rChosenChReg;
   assign bus.rHopsFromCH        = rHopsFromChReg;
   assign bus.rPacketType        = rTypeReg;
   assign bus.nTableIndex_reward = idxReg;
   assign bus.reward_done        = doneReg;

   // Inputs carried on the bus for other consumers; not needed here.
   assign unusedInputs = ^{bus.myQValue, bus.iHaveData, bus.fSourceHops, bus.fEnergyLeft,
                           bus.fHopsFromCH, bus.fChosenCH, bus.chosenHop,
                           bus.mNodeID, bus.mNodeHops, bus.mNodeCHHops};
endmodule

// File: tb/tb_reward_unit.sv
// tb_reward_unit
// Directed scenarios plus randomized packets against a behavioural model of
// the reward rules (best live neighbor Q, halved energy, optional hop
// penalty, saturation, low-energy override, response field selection).
module tb_reward_unit;
   import reward_unit_pkg::*;

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   reward_unit_if bus();

   reward_unit dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus.slave)
   );

   logic [15:0] tblQ [32];
   logic [15:0] tblE [32];

   always_comb begin
      bus.mNodeQValue = tblQ[bus.nTableIndex_reward[4:0]];
      bus.mNodeEnergy = tblE[bus.nTableIndex_reward[4:0]];
      bus.mNodeID     = {11'd0, bus.nTableIndex_reward[4:0]};
      bus.mNodeHops   = 16'd3;
      bus.mNodeCHHops = 16'd2;
   end

   int testsRun = 0;
   int testsFailed = 0;

   // Expected response state (held between accepted packets).
   logic [15:0] eSrc, eEnergy, eQ, eHops, eDest, eCh, eHopsCh;
   logic [2:0]  eType;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      testsRun++;
      if (got !== want) begin
         testsFailed++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [15:0] refQ(input logic [15:0] myE, input logic [15:0] hops,
                                        input logic [15:0] bestQ, input logic lowE);
      int r;
      int q;
      r = int'(myE) / 2;
`ifdef REWARD_HOP_PENALTY_EN
      r = r - int'(hops) * 256;
      if (r < 0) r = 0;
`else
      if (hops == 16'hFFFF) r = r + 0;
`endif
      q = r + int'(bestQ) / 2;
      if (q > 65535) q = 65535;
      if (lowE) q = 0;
      return q[15:0];
   endfunction

   task automatic checkOutputs(input string name);
      check({name, "_rSourceID"}, 32'(bus.rSourceID), 32'(eSrc));
      check({name, "_rEnergyLeft"}, 32'(bus.rEnergyLeft), 32'(eEnergy));
      check({name, "_rQValue"}, 32'(bus.rQValue), 32'(eQ));
      check({name, "_rSourceHops"}, 32'(bus.rSourceHops), 32'(eHops));
      check({name, "_rDestinationID"}, 32'(bus.rDestinationID), 32'(eDest));
      check({name, "_rChosenCH"}, 32'(bus.rChosenCH), 32'(eCh));
      check({name, "_rHopsFromCH"}, 32'(bus.rHopsFromCH), 32'(eHopsCh));
      check({name, "_rPacketType"}, 32'(bus.rPacketType), 32'(eType));
   endtask

   // One packet: pulse en, follow the index/done timing, compare the response.
   task automatic runTxn(input logic [2:0] ptype, input logic dest, input int n, input string name);
      bit acc;
      int expLat;
      int lat;
      int best;
      acc = (ptype == 3'd0) || (ptype == 3'd3 && dest);
      expLat = acc ? n + 1 : 0;
      lat = -1;
      @(negedge clk);
      bus.fPacketType    = ptype;
      bus.iAmDestination = dest;
      bus.neighborCount  = 5'(n);
      bus.en             = 1'b1;
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      if (acc) begin
         best = (ptype == 3'd3) ? int'(bus.fQValue) : 0;
         for (int i = 0; i < n; i++)
            if (tblE[i] != 16'd0 && int'(tblQ[i]) > best) best = int'(tblQ[i]);
         eSrc    = bus.myNodeID;
         eEnergy = bus.myEnergy;
         eQ      = refQ(bus.myEnergy, bus.hopsFromSink, 16'(best), bus.low_E);
         eHops   = bus.hopsFromSink;
         eCh     = bus.chosenCH;
         eHopsCh = bus.role ? 16'd0 : bus.hopsFromCH;
         eType   = (ptype == 3'd3) ? 3'd4 : 3'd0;
         eDest   = (ptype == 3'd3) ? bus.fSourceID : 16'hFFFF;
      end
      for (int c = 0; c < 80; c++) begin
         check({name, "_index"}, 32'(bus.nTableIndex_reward), (acc && c < n) ? 32'(c) : 32'd0);
         if (bus.reward_done) begin
            lat = c;
            break;
         end
         @(posedge clk);
         #1;
      end
      check({name, "_latency"}, 32'(lat), 32'(expLat));
      checkOutputs(name);
      @(posedge clk);
      #1;
      check({name, "_doneLow"}, 32'(bus.reward_done), 32'd0);
      $display("[TB] txn %s type=%0d dest=%0d n=%0d lat=%0d rQValue=%h rType=%0d",
               name, ptype, dest, n, lat, bus.rQValue, bus.rPacketType);
   endtask

   initial begin
      int pulses;
      nrst = 1'b1;
      bus.en = 0; bus.fPacketType = 0; bus.myEnergy = 0; bus.myNodeID = 0;
      bus.hopsFromSink = 0; bus.myQValue = 0; bus.iHaveData = 0; bus.iAmDestination = 0;
      bus.role = 0; bus.low_E = 0; bus.fSourceID = 0; bus.fSourceHops = 0; bus.fQValue = 0;
      bus.fEnergyLeft = 0; bus.fHopsFromCH = 0; bus.fChosenCH = 0; bus.chosenCH = 0;
      bus.hopsFromCH = 0; bus.chosenHop = 0; bus.neighborCount = 0;
      for (int i = 0; i < 32; i++) begin tblQ[i] = 0; tblE[i] = 0; end
      eSrc = 0; eEnergy = 0; eQ = 0; eHops = 0; eDest = 0; eCh = 0; eHopsCh = 0; eType = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutputs("reset");
      check("reset_index", 32'(bus.nTableIndex_reward), 32'd0);
      check("reset_done", 32'(bus.reward_done), 32'd0);
      @(negedge clk);
      nrst = 1'b0;

      // HB with empty table.
      bus.myEnergy = 16'h8000; bus.hopsFromSink = 16'd1; bus.myNodeID = 16'h000C;
      bus.chosenCH = 16'h0021; bus.hopsFromCH = 16'd2; bus.role = 1'b0;
      runTxn(3'd0, 1'b0, 0, "hbEmpty");
`ifdef REWARD_HOP_PENALTY_EN
      check("hbEmpty_const", 32'(bus.rQValue), 32'h3F00);
`else
      check("hbEmpty_const", 32'(bus.rQValue), 32'h4000);
`endif

      // HB with three live neighbors.
      tblQ[0] = 16'h2000; tblQ[1] = 16'h6000; tblQ[2] = 16'h1000;
      tblE[0] = 16'h1111; tblE[1] = 16'h2222; tblE[2] = 16'h3333;
      runTxn(3'd0, 1'b0, 3, "hbThree");
`ifdef REWARD_HOP_PENALTY_EN
      check("hbThree_const", 32'(bus.rQValue), 32'h6F00);
`else
      check("hbThree_const", 32'(bus.rQValue), 32'h7000);
`endif

      // Best entry is dead, so it must be skipped.
      tblE[1] = 16'h0000;
      bus.role = 1'b1;
      runTxn(3'd0, 1'b0, 3, "hbDead");

      // DATA addressed to us.
      bus.fSourceID = 16'h0007; bus.fQValue = 16'h8000; bus.hopsFromSink = 16'd0;
      runTxn(3'd3, 1'b1, 0, "dataDest");
      check("dataDest_const", 32'(bus.rQValue), 32'h8000);

      // Rejected packets leave outputs untouched.
      bus.myNodeID = 16'h0055; bus.myEnergy = 16'h1234;
      runTxn(3'd3, 1'b0, 4, "dataNotDest");
      runTxn(3'd1, 1'b1, 2, "chAdv");

      // Low energy forces zero reward.
      bus.low_E = 1'b1;
      runTxn(3'd0, 1'b0, 3, "hbLowE");
      bus.low_E = 1'b0;

      // Reset during SCAN aborts without a done pulse.
      for (int i = 0; i < 5; i++) begin tblQ[i] = 16'h0F00 + 16'(i); tblE[i] = 16'h0001; end
      @(negedge clk);
      bus.fPacketType = 3'd0; bus.neighborCount = 5'd5; bus.en = 1'b1;
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      @(posedge clk);
      #2;
      nrst = 1'b1;
      #1;
      eSrc = 0; eEnergy = 0; eQ = 0; eHops = 0; eDest = 0; eCh = 0; eHopsCh = 0; eType = 0;
      checkOutputs("midReset");
      check("midReset_index", 32'(bus.nTableIndex_reward), 32'd0);
      pulses = 0;
      repeat (2) begin
         @(negedge clk);
         if (bus.reward_done) pulses++;
      end
      nrst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.reward_done) pulses++;
      end
      check("midReset_noDone", 32'(pulses), 32'd0);
      runTxn(3'd0, 1'b0, 5, "afterReset");

      // Randomized packets.
      for (int t = 0; t < 40; t++) begin
         logic [2:0] ptype;
         int n;
         case ($urandom_range(0, 3))
            0, 1:    ptype = 3'd0;
            2:       ptype = 3'd3;
            default: ptype = 3'($urandom_range(0, 7));
         endcase
         n = $urandom_range(0, 31);
         for (int i = 0; i < 32; i++) begin
            tblQ[i] = 16'($urandom);
            tblE[i] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         end
         bus.myEnergy     = 16'($urandom);
         bus.hopsFromSink = 16'($urandom_range(0, 80));
         bus.myNodeID     = 16'($urandom);
         bus.chosenCH     = 16'($urandom);
         bus.hopsFromCH   = 16'($urandom_range(0, 15));
         bus.role         = 1'($urandom_range(0, 1));
         bus.low_E        = ($urandom_range(0, 7) == 0);
         bus.fSourceID    = 16'($urandom);
         bus.fQValue      = 16'($urandom);
         runTxn(ptype, 1'($urandom_range(0, 1)), n, $sformatf("rand%0d", t));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule

// File: doc/reward_unit.md
# reward_unit

Computes a node's EER-RL Q-value reward and assembles the fields of the outgoing reward/advertisement packet. Sits between the packet filter / node-info registers and the transmit packet builder. On an accepted packet it scans the neighbor table for the best neighbor Q-value, combines it with its own residual energy, and registers a complete response packet.

## Interface
- No parameters; `WORD_WIDTH` = 16.
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous reset, active-high (1 = reset).
- en  in  1  start pulse; sampled only in IDLE.
- fPacketType  in  3  received packet type.
- myEnergy, myNodeID, hopsFromSink, myQValue  in  16  own node info (energy UQ1.15, 16'h8000 = 1.0).
- iHaveData  in  1  reserved, no effect.
- iAmDestination  in  1  packet filter: this node is addressee.
- role  in  1  1 = cluster head.
- low_E  in  1  own energy below threshold.
- fSourceID, fSourceHops, fQValue, fEnergyLeft, fHopsFromCH, fChosenCH  in  16  received packet fields.
- chosenCH, hopsFromCH, chosenHop  in  16  cluster/routing state.
- neighborCount  in  5  valid neighbor-table entries.
- mNodeID, mNodeHops, mNodeQValue, mNodeEnergy, mNodeCHHops  in  16  table entry at nTableIndex_reward, same-cycle (combinational) read.
- rSourceID, rEnergyLeft, rQValue, rSourceHops, rDestinationID, rChosenCH, rHopsFromCH  out  16  response packet fields.
- rPacketType  out  3  response type.
- nTableIndex_reward  out  6  neighbor-table read index.
- reward_done  out  1  one-cycle completion strobe.

## Operation
- Types: 0 HB, 1 CH_ADV, 2 CH_JOIN, 3 DATA, 4 ACK, 5 SOS, 6 CH_TIMEOUT, 7 reserved.
- Accepted: HB (always); DATA only if iAmDestination=1. Others: no output update, done strobe only.
- FSM IDLE, SCAN, CALC, DONE.
- IDLE: en=1 and accepted → latch f* fields; maxQ = fQValue for DATA, 0 for HB; idx=0; next SCAN if neighborCount>0 else CALC. en=1, not accepted → DONE. en=0 → stay.
- SCAN: nTableIndex_reward=idx; if mNodeEnergy≠0 and mNodeQValue>maxQ, maxQ=mNodeQValue; idx++; after entry neighborCount-1 → CALC.
- CALC: r = myEnergy>>1; Q = r + (maxQ>>1), saturate 16'hFFFF; low_E=1 forces Q=0. Register outputs: rSourceID=myNodeID, rEnergyLeft=myEnergy, rQValue=Q, rSourceHops=hopsFromSink, rChosenCH=chosenCH, rHopsFromCH=(role?0:hopsFromCH). HB → rPacketType=0, rDestinationID=16'hFFFF. DATA → rPacketType=4, rDestinationID=latched fSourceID. → DONE.
- DONE: reward_done=1 → IDLE.
- en outside IDLE ignored. Reset mid-operation aborts to IDLE.

## Timing
- Reset: all r* outputs 0, nTableIndex_reward 0, reward_done 0, state IDLE.
- en sampled at edge k, N=neighborCount: accepted → reward_done high for the cycle following edge k+N+1 (N=0 → after k+1); rejected → after edge k.
- r* outputs change only at the CALC edge and hold until the next accepted packet.
- nTableIndex_reward 0 outside SCAN; bit 5 always 0.

## Configuration
- REWARD_HOP_PENALTY_EN defined: r = (myEnergy>>1) − (hopsFromSink<<8), floored at 0, before adding maxQ>>1.
- Undefined: r = myEnergy>>1; hopsFromSink affects only rSourceHops.

## Structure
- Shared package: WORD_WIDTH, packet-type enum (HB…CH_TIMEOUT), broadcast ID 16'hFFFF, FSM state enum.
- One natural sub-module: reward_qcalc (combinational shift/penalty/saturating add, low_E override).

## Test plan
- Reset, myEnergy=16'h8000, hopsFromSink=1, myNodeID=16'h000C, HB en pulse, N=0 → done one cycle after edge k+1; rQValue=16'h4000 (16'h3F00 with REWARD_HOP_PENALTY_EN), rSourceID=16'h000C, rDestinationID=16'hFFFF, rPacketType=0.
- HB, N=3, mNodeQValue {16'h2000,16'h6000,16'h1000}, energies nonzero → indices 0,1,2 driven; rQValue=16'h4000+16'h3000=16'h7000; done after edge k+4.
- Same table but entry 1 mNodeEnergy=0 → maxQ=16'h2000, rQValue=16'h5000.
- DATA, iAmDestination=1, fSourceID=16'h0007, fQValue=16'h8000, N=0 → rPacketType=4, rDestinationID=16'h0007, rQValue=16'h8000.
- DATA with iAmDestination=0, or CH_ADV → done after edge k, outputs unchanged; low_E=1 on accepted HB → rQValue=0.
- Assert nrst during SCAN → outputs reset, done never pulses, later en restarts cleanly.
